// File: rtl/pio_in_irq.sv
// Avalon-MM input port: synchronises and debounces external inputs, captures
// selected edges into a sticky write-1-to-clear register and raises a maskable level irq.
module pio_in_irq #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int D  = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
   localparam int CW = $clog2(D + 1);
   localparam logic [CW-1:0] D_LAST = CW'(D - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_v;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] clr;
   logic [CW-1:0]    cnt [WIDTH];
   logic [31:0]      rd_val;
   logic             wr;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;
   assign wr           = chipselect & ~write_n;
   assign sync_out     = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // A mismatch must persist D consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_out[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == D_LAST) begin
               db[i]  <= sync_out[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

   assign rise = db & ~prev;
   assign fall = ~db & prev;

   always_comb begin
      edge_v = '0;
      case (EDGE_TYPE)
         0:       edge_v = rise;
         1:       edge_v = fall;
         default: edge_v = rise | fall;
      endcase
   end

   assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // New edges win over a simultaneous clear so no event is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev    <= '0;
         capture <= '0;
         mask    <= '0;
      end else begin
         prev    <= db;
         capture <= (capture & ~clr) | edge_v;
         if (wr && address == 2'd2) mask <= writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      rd_val = '0;
      case (address)
         2'd0:    rd_val[WIDTH-1:0] = db;
         2'd1:    rd_val[WIDTH-1:0] = sync_out;
         2'd2:    rd_val[WIDTH-1:0] = mask;
         default: rd_val[WIDTH-1:0] = capture;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_val;
   end

   assign irq = |(capture & mask);

endmodule

// File: tb/tb_pio_in_irq.sv
// Directed bench for pio_in_irq: a default instance and an 8-bit falling-edge,
// undebounced instance, checked against hand-computed values.
`timescale 1ns/1ps
module tb_pio_in_irq;

   logic        clk = 1'b0;
   logic        reset_n;

   logic [1:0]  a_address;
   logic        a_cs;
   logic        a_write_n;
   logic [31:0] a_wdata;
   logic [31:0] a_rdata;
   logic [3:0]  a_in;
   logic        a_irq;

   logic [1:0]  b_address;
   logic        b_cs;
   logic        b_write_n;
   logic [31:0] b_wdata;
   logic [31:0] b_rdata;
   logic [7:0]  b_in;
   logic        b_irq;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] d;

   always #5 clk = ~clk;

   pio_in_irq u_a (
      .clk(clk), .reset_n(reset_n), .address(a_address), .chipselect(a_cs),
      .write_n(a_write_n), .writedata(a_wdata), .readdata(a_rdata),
      .in_port(a_in), .irq(a_irq)
   );

   pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(0), .EDGE_TYPE(1)) u_b (
      .clk(clk), .reset_n(reset_n), .address(b_address), .chipselect(b_cs),
      .write_n(b_write_n), .writedata(b_wdata), .readdata(b_rdata),
      .in_port(b_in), .irq(b_irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      repeat (10) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic a_wr(input logic [1:0] addr, input logic [31:0] data);
      a_address = addr; a_cs = 1'b1; a_write_n = 1'b0; a_wdata = data;
      tick();
      a_cs = 1'b0; a_write_n = 1'b1;
   endtask

   task automatic a_rd(input logic [1:0] addr, output logic [31:0] data);
      a_address = addr;
      tick();
      data = a_rdata;
   endtask

   task automatic b_wr(input logic [1:0] addr, input logic [31:0] data);
      b_address = addr; b_cs = 1'b1; b_write_n = 1'b0; b_wdata = data;
      tick();
      b_cs = 1'b0; b_write_n = 1'b1;
   endtask

   task automatic b_rd(input logic [1:0] addr, output logic [31:0] data);
      b_address = addr;
      tick();
      data = b_rdata;
   endtask

   initial begin
      reset_n = 1'b0;
      a_address = 2'd0; a_cs = 1'b0; a_write_n = 1'b1; a_wdata = '0; a_in = '0;
      b_address = 2'd0; b_cs = 1'b0; b_write_n = 1'b1; b_wdata = '0; b_in = '0;
      repeat (3) tick();
      check("rst_rdata_a", a_rdata, 32'h0);
      check("rst_irq_a", {31'b0, a_irq}, 32'h0);
      check("rst_rdata_b", b_rdata, 32'h0);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_rd(2'(i), d);
         check($sformatf("rst_read%0d", i), d, 32'h0);
      end
      check("rst_irq_run", {31'b0, a_irq}, 32'h0);

      // reset in the middle of a debounce count
      a_in = 4'b0010;
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      check("midrst_rdata", a_rdata, 32'h0);
      a_in = 4'b0000;
      tick();
      reset_n = 1'b1;
      repeat (8) tick();
      a_rd(2'd0, d);
      check("midrst_db", d, 32'h0);
      a_rd(2'd3, d);
      check("midrst_cap", d, 32'h0);

      // default timing: db at edge 6, capture/irq at edge 7
      a_wr(2'd2, 32'hF);
      a_rd(2'd2, d);
      check("mask_rb_f", d, 32'hF);
      a_in = 4'b0001; a_address = 2'd0;
      repeat (6) tick();
      check("db_edge6_rd", a_rdata, 32'h0);
      check("irq_edge6", {31'b0, a_irq}, 32'h0);
      tick();
      check("db_edge7_rd", a_rdata, 32'h1);
      check("irq_edge7", {31'b0, a_irq}, 32'h1);
      a_rd(2'd3, d);
      check("cap_edge7", d, 32'h1);

      // bounce on bit 1 shorter than the debounce window
      a_wr(2'd3, 32'hF);
      check("irq_cleared", {31'b0, a_irq}, 32'h0);
      a_in = 4'b0011; a_address = 2'd1;
      repeat (3) tick();
      a_in = 4'b0001;
      tick();
      check("sync_hi", a_rdata, 32'h3);
      a_in = 4'b0011;
      repeat (2) tick();
      check("sync_lo", a_rdata, 32'h1);
      tick();
      a_in = 4'b0001;
      tick();
      check("sync_hi2", a_rdata, 32'h3);
      repeat (2) tick();
      check("sync_lo2", a_rdata, 32'h1);
      repeat (2) tick();
      a_rd(2'd0, d);
      check("bounce_db", d, 32'h1);
      a_rd(2'd3, d);
      check("bounce_cap", d, 32'h0);
      check("bounce_irq", {31'b0, a_irq}, 32'h0);

      // clear racing a new rising edge on bit 0
      a_in = 4'b0000;
      settle();
      a_rd(2'd3, d);
      check("fall_nocap", d, 32'h0);
      a_in = 4'b0001;
      settle();
      a_rd(2'd3, d);
      check("cap_b0", d, 32'h1);
      a_in = 4'b0000;
      settle();
      a_in = 4'b0001;
      repeat (6) tick();
      a_wr(2'd3, 32'h1);
      check("irq_race", {31'b0, a_irq}, 32'h1);
      a_rd(2'd3, d);
      check("cap_race", d, 32'h1);

      // write-1-to-clear and unmasking
      a_in = 4'b0101;
      settle();
      a_rd(2'd3, d);
      check("cap_0101", d, 32'h5);
      a_wr(2'd3, 32'h1);
      a_rd(2'd3, d);
      check("cap_w1c", d, 32'h4);
      check("irq_b2", {31'b0, a_irq}, 32'h1);
      a_wr(2'd2, 32'h1);
      check("irq_masked", {31'b0, a_irq}, 32'h0);
      a_rd(2'd2, d);
      check("mask_rb_1", d, 32'h1);
      a_wr(2'd0, 32'hF);
      a_wr(2'd1, 32'hF);
      a_rd(2'd0, d);
      check("db_ro", d, 32'h5);
      a_rd(2'd1, d);
      check("sync_ro", d, 32'h5);

      // falling-edge instance, no debounce
      b_in = 8'hFF;
      repeat (6) tick();
      b_wr(2'd3, 32'hFF);
      b_rd(2'd3, d);
      check("b_cap_clr", d, 32'h0);
      b_rd(2'd0, d);
      check("b_db_ff", d, 32'hFF);
      b_in = 8'h7F; b_address = 2'd3;
      repeat (4) tick();
      check("b_cap_edge4", b_rdata, 32'h0);
      tick();
      check("b_cap_edge5", b_rdata, 32'h80);
      check("b_irq_masked", {31'b0, b_irq}, 32'h0);
      b_rd(2'd0, d);
      check("b_db_7f", d, 32'h0000_007F);
      b_wr(2'd2, 32'hFF);
      check("b_irq_on", {31'b0, b_irq}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
